mem_bus_arbiter: RTL and testbench

Shares the single NLP-16AF memory port between the CPU core and an external requester (loader/DMA/debug). The arbiter accepts one access at a time from either side and runs a fixed-length memory cycle with a programmable wait-state count. It returns a one-cycle acknowledge and read data to the winning requester only. It sits between the core's memory strobes/address bus and the memory macro.

---
 rtl/mem_bus_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_bus_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-requester (CPU / external) arbiter for the single memory port with a fixed-length, wait-stated cycle.
// Optional round-robin tie-breaking is enabled by defining MEM_ARB_RR_EN; otherwise the CPU has fixed priority.
module mem_bus_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  output logic [DATA_W-1:0] o_cpu_rdata,
  output logic              o_cpu_ack,
  input  logic              i_ext_req,
  input  logic              i_ext_we,
  input  logic [ADDR_W-1:0] i_ext_addr,
  input  logic [DATA_W-1:0] i_ext_wdata,
  output logic [DATA_W-1:0] o_ext_rdata,
  output logic              o_ext_ack,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_mem_rd,
  output logic              o_mem_wr,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_busy,
  output logic              o_owner
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t            state, state_nxt;
  logic [3:0]        cnt;
  logic              we_q;
  logic              owner_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] ext_rdata_q;
  logic              grant;
  logic              grant_ext;

  assign grant = (state == IDLE) && (i_cpu_req || i_ext_req);

`ifdef MEM_ARB_RR_EN
  // last_ext remembers who was granted last; resetting it to 1 hands the first tie to the CPU.
  logic last_ext;

  assign grant_ext = i_ext_req && (!i_cpu_req || !last_ext);

  always_ff @(posedge i_clk) begin
    if (i_rst)      last_ext <= 1'b1;
    else if (grant) last_ext <= grant_ext;
  end
`else
  assign grant_ext = i_ext_req && !i_cpu_req;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: next state gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = ACCESS;
      ACCESS:  if (cnt == 4'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt         <= 4'd0;
      we_q        <= 1'b0;
      owner_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      ext_rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            owner_q <= grant_ext;
            we_q    <= grant_ext ? i_ext_we    : i_cpu_we;
            addr_q  <= grant_ext ? i_ext_addr  : i_cpu_addr;
            wdata_q <= grant_ext ? i_ext_wdata : i_cpu_wdata;
            cnt     <= CNT_LOAD;
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            // Read data is only valid in the final strobe cycle.
            if (!we_q) begin
              if (owner_q) ext_rdata_q <= i_mem_rdata;
              else         cpu_rdata_q <= i_mem_rdata;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;
  assign o_mem_rd    = (state == ACCESS) && !we_q;
  assign o_mem_wr    = (state == ACCESS) &&  we_q;
  assign o_cpu_ack   = (state == DONE)   && !owner_q;
  assign o_ext_ack   = (state == DONE)   &&  owner_q;
  assign o_cpu_rdata = cpu_rdata_q;
  assign o_ext_rdata = ext_rdata_q;
  assign o_busy      = (state != IDLE);
  assign o_owner     = owner_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: per-cycle vector table plus directed multi-cycle sequences.
// Tie-order expectations follow MEM_ARB_RR_EN when it is defined for the build.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, ext_req, ext_we;
  logic [15:0] cpu_addr, cpu_wdata, ext_addr, ext_wdata, mem_rdata;
  logic [15:0] cpu_rdata, ext_rdata, mem_addr, mem_wdata;
  logic        cpu_ack, ext_ack, mem_rd, mem_wr, busy, owner;

  // Extra instances for the WAIT_CYCLES extremes; only their CPU request moves.
  logic        zero1 = 1'b0;
  logic [15:0] zero16 = 16'h0000;
  logic        a_req, b_req;
  logic [15:0] a_crd, a_erd, a_addr, a_wdata, b_crd, b_erd, b_addr, b_wdata;
  logic        a_cack, a_eack, a_rd, a_wr, a_busy, a_own;
  logic        b_cack, b_eack, b_rd, b_wr, b_busy, b_own;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(2)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
    .o_cpu_rdata(cpu_rdata), .o_cpu_ack(cpu_ack),
    .i_ext_req(ext_req), .i_ext_we(ext_we), .i_ext_addr(ext_addr), .i_ext_wdata(ext_wdata),
    .o_ext_rdata(ext_rdata), .o_ext_ack(ext_ack),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_rd(mem_rd), .o_mem_wr(mem_wr),
    .i_mem_rdata(mem_rdata), .o_busy(busy), .o_owner(owner)
  );

  mem_bus_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(1)) dut_w1 (
    .i_clk(clk), .i_rst(rst),
    .i_cpu_req(a_req), .i_cpu_we(zero1), .i_cpu_addr(zero16), .i_cpu_wdata(zero16),
    .o_cpu_rdata(a_crd), .o_cpu_ack(a_cack),
    .i_ext_req(zero1), .i_ext_we(zero1), .i_ext_addr(zero16), .i_ext_wdata(zero16),
    .o_ext_rdata(a_erd), .o_ext_ack(a_eack),
    .o_mem_addr(a_addr), .o_mem_wdata(a_wdata), .o_mem_rd(a_rd), .o_mem_wr(a_wr),
    .i_mem_rdata(zero16), .o_busy(a_busy), .o_owner(a_own)
  );

  mem_bus_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(15)) dut_w15 (
    .i_clk(clk), .i_rst(rst),
    .i_cpu_req(b_req), .i_cpu_we(zero1), .i_cpu_addr(zero16), .i_cpu_wdata(zero16),
    .o_cpu_rdata(b_crd), .o_cpu_ack(b_cack),
    .i_ext_req(zero1), .i_ext_we(zero1), .i_ext_addr(zero16), .i_ext_wdata(zero16),
    .o_ext_rdata(b_erd), .o_ext_ack(b_eack),
    .o_mem_addr(b_addr), .o_mem_wdata(b_wdata), .o_mem_rd(b_rd), .o_mem_wr(b_wr),
    .i_mem_rdata(zero16), .o_busy(b_busy), .o_owner(b_own)
  );

  typedef struct {
    logic        cpu_req, cpu_we;
    logic [15:0] cpu_addr, cpu_wdata;
    logic        ext_req, ext_we;
    logic [15:0] ext_addr, ext_wdata, mem_rdata;
    logic        x_rd, x_wr;
    logic [15:0] x_addr, x_wdata;
    logic        x_cack, x_eack;
    logic [15:0] x_crd, x_erd;
    logic        x_busy, x_owner;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   n, lat, width, first_ack, last_ack;
    logic [3:0] seq, exp_seq;

    // Columns: cpu req/we/addr/wdata | ext req/we/addr/wdata | mem_rdata || rd wr addr wdata | cack eack crd erd | busy owner
    // CPU read 0x0100; only the last strobe cycle's data (0xBEEF) may be captured.
    vecs.push_back('{1'b1,1'b0,16'h0100,16'h0000, 1'b0,1'b0,16'h0000,16'h0000, 16'h0000, 1'b1,1'b0,16'h0100,16'h0000, 1'b0,1'b0,16'h0000,16'h0000, 1'b1,1'b0});
    vecs.push_back('{1'b1,1'b0,16'h0100,16'h0000, 1'b0,1'b0,16'h0000,16'h0000, 16'hDEAD, 1'b1,1'b0,16'h0100,16'h0000, 1'b0,1'b0,16'h0000,16'h0000, 1'b1,1'b0});
    vecs.push_back('{1'b1,1'b0,16'h0100,16'h0000, 1'b0,1'b0,16'h0000,16'h0000, 16'hBEEF, 1'b0,1'b0,16'h0100,16'h0000, 1'b1,1'b0,16'hBEEF,16'h0000, 1'b1,1'b0});
    vecs.push_back('{1'b0,1'b0,16'h0100,16'h0000, 1'b0,1'b0,16'h0000,16'h0000, 16'h0000, 1'b0,1'b0,16'h0100,16'h0000, 1'b0,1'b0,16'hBEEF,16'h0000, 1'b0,1'b0});
    // CPU write 0x0200 <= 0xABCD; read registers untouched.
    vecs.push_back('{1'b1,1'b1,16'h0200,16'hABCD, 1'b0,1'b0,16'h0000,16'h0000, 16'h5555, 1'b0,1'b1,16'h0200,16'hABCD, 1'b0,1'b0,16'hBEEF,16'h0000, 1'b1,1'b0});
    vecs.push_back('{1'b1,1'b1,16'h0200,16'hABCD, 1'b0,1'b0,16'h0000,16'h0000, 16'h5555, 1'b0,1'b1,16'h0200,16'hABCD, 1'b0,1'b0,16'hBEEF,16'h0000, 1'b1,1'b0});
    vecs.push_back('{1'b1,1'b1,16'h0200,16'hABCD, 1'b0,1'b0,16'h0000,16'h0000, 16'h5555, 1'b0,1'b0,16'h0200,16'hABCD, 1'b1,1'b0,16'hBEEF,16'h0000, 1'b1,1'b0});
    vecs.push_back('{1'b0,1'b0,16'h0000,16'h0000, 1'b0,1'b0,16'h0000,16'h0000, 16'h0000, 1'b0,1'b0,16'h0200,16'hABCD, 1'b0,1'b0,16'hBEEF,16'h0000, 1'b0,1'b0});
    // External write 0x2000 <= 0x1234.
    vecs.push_back('{1'b0,1'b0,16'h0000,16'h0000, 1'b1,1'b1,16'h2000,16'h1234, 16'h5555, 1'b0,1'b1,16'h2000,16'h1234, 1'b0,1'b0,16'hBEEF,16'h0000, 1'b1,1'b1});
    vecs.push_back('{1'b0,1'b0,16'h0000,16'h0000, 1'b1,1'b1,16'h2000,16'h1234, 16'h5555, 1'b0,1'b1,16'h2000,16'h1234, 1'b0,1'b0,16'hBEEF,16'h0000, 1'b1,1'b1});
    vecs.push_back('{1'b0,1'b0,16'h0000,16'h0000, 1'b1,1'b1,16'h2000,16'h1234, 16'h5555, 1'b0,1'b0,16'h2000,16'h1234, 1'b0,1'b1,16'hBEEF,16'h0000, 1'b1,1'b1});
    vecs.push_back('{1'b0,1'b0,16'h0000,16'h0000, 1'b0,1'b0,16'h0000,16'h0000, 16'h0000, 1'b0,1'b0,16'h2000,16'h1234, 1'b0,1'b0,16'hBEEF,16'h0000, 1'b0,1'b0});
    // External read 0x3000 returning 0xA5A5; CPU register keeps 0xBEEF.
    vecs.push_back('{1'b0,1'b0,16'h0000,16'h0000, 1'b1,1'b0,16'h3000,16'h0000, 16'h0000, 1'b1,1'b0,16'h3000,16'h0000, 1'b0,1'b0,16'hBEEF,16'h0000, 1'b1,1'b1});
    vecs.push_back('{1'b0,1'b0,16'h0000,16'h0000, 1'b1,1'b0,16'h3000,16'h0000, 16'h0000, 1'b1,1'b0,16'h3000,16'h0000, 1'b0,1'b0,16'hBEEF,16'h0000, 1'b1,1'b1});
    vecs.push_back('{1'b0,1'b0,16'h0000,16'h0000, 1'b1,1'b0,16'h3000,16'h0000, 16'hA5A5, 1'b0,1'b0,16'h3000,16'h0000, 1'b0,1'b1,16'hBEEF,16'hA5A5, 1'b1,1'b1});
    vecs.push_back('{1'b0,1'b0,16'h0000,16'h0000, 1'b0,1'b0,16'h0000,16'h0000, 16'h0000, 1'b0,1'b0,16'h3000,16'h0000, 1'b0,1'b0,16'hBEEF,16'hA5A5, 1'b0,1'b0});
    // Idle with no request: address lines hold the last latched command.
    vecs.push_back('{1'b0,1'b0,16'h9999,16'h7777, 1'b0,1'b0,16'h8888,16'h6666, 16'h4444, 1'b0,1'b0,16'h3000,16'h0000, 1'b0,1'b0,16'hBEEF,16'hA5A5, 1'b0,1'b0});

    rst = 1'b1; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    ext_req = 0; ext_we = 0; ext_addr = 0; ext_wdata = 0; mem_rdata = 0;
    a_req = 0; b_req = 0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("reset_ctrl", {mem_rd, mem_wr, mem_addr, mem_wdata, cpu_ack, ext_ack, busy, owner}, 64'h0);
    check("reset_rdata", {cpu_rdata, ext_rdata}, 64'h0);

    // Table-driven per-cycle vectors.
    foreach (vecs[i]) begin
      v = vecs[i];
      cpu_req = v.cpu_req; cpu_we = v.cpu_we; cpu_addr = v.cpu_addr; cpu_wdata = v.cpu_wdata;
      ext_req = v.ext_req; ext_we = v.ext_we; ext_addr = v.ext_addr; ext_wdata = v.ext_wdata;
      mem_rdata = v.mem_rdata;
      tick();
      check($sformatf("vec%0d_mem", i), {mem_rd, mem_wr, mem_addr, mem_wdata},
            {v.x_rd, v.x_wr, v.x_addr, v.x_wdata});
      check($sformatf("vec%0d_req", i), {cpu_ack, ext_ack, cpu_rdata, ext_rdata, busy, owner & busy},
            {v.x_cack, v.x_eack, v.x_crd, v.x_erd, v.x_busy, v.x_owner & v.x_busy});
    end

    // Both requesters held continuously for four accesses; the last grant above went to ext.
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0A00;
    ext_req = 1; ext_we = 0; ext_addr = 16'h0B00;
    mem_rdata = 16'h0000;
    n = 0; seq = 4'b0; first_ack = 0; last_ack = 0;
    for (int c = 1; c <= 60 && n < 4; c++) begin
      tick();
      if (cpu_ack || ext_ack) begin
        seq[n] = ext_ack;
        if (n == 0) first_ack = c;
        last_ack = c;
        n++;
        if (n == 4) begin
          cpu_req = 0;
          ext_req = 0;
        end
      end
    end
`ifdef MEM_ARB_RR_EN
    exp_seq = 4'b1010;
`else
    exp_seq = 4'b0000;
`endif
    check("tie_count", n, 4);
    check("tie_order", seq, exp_seq);
    check("tie_period", last_ack - first_ack, 12);
    tick();
    check("tie_idle", busy, 1'b0);

    // CPU drops req and changes address after the first strobe cycle.
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0400;
    tick();
    check("drop_first", {mem_rd, mem_addr}, {1'b1, 16'h0400});
    cpu_req = 0; cpu_addr = 16'hFFFF;
    tick();
    check("drop_second", {mem_rd, mem_addr}, {1'b1, 16'h0400});
    mem_rdata = 16'h7777;
    tick();
    check("drop_ack", {cpu_ack, ext_ack, cpu_rdata}, {1'b1, 1'b0, 16'h7777});
    mem_rdata = 16'h0000;
    tick();
    check("drop_idle", {busy, cpu_ack, mem_addr}, {1'b0, 1'b0, 16'h0400});

    // Reset during the second ACCESS cycle of a write.
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0500; cpu_wdata = 16'hCAFE;
    tick();
    tick();
    check("rst_pre", {mem_wr, busy}, {1'b1, 1'b1});
    rst = 1; cpu_req = 0;
    tick();
    check("rst_ctrl", {mem_rd, mem_wr, mem_addr, mem_wdata, cpu_ack, ext_ack, busy, owner}, 64'h0);
    check("rst_rdata", {cpu_rdata, ext_rdata}, 64'h0);
    rst = 0;
    tick();
    check("rst_no_ack", {cpu_ack, ext_ack, busy}, 3'b000);

    // Fresh read after reset.
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0600; mem_rdata = 16'h1111;
    lat = 0;
    for (int c = 1; c <= 10 && lat == 0; c++) begin
      tick();
      if (cpu_ack) begin
        lat = c;
        cpu_req = 0;
      end
    end
    check("fresh_latency", lat, 3);
    check("fresh_rdata", cpu_rdata, 16'h1111);
    tick();

    // WAIT_CYCLES = 1.
    a_req = 1; lat = 0; width = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (a_rd) width++;
      if (a_cack && lat == 0) begin
        lat = c;
        a_req = 0;
      end
    end
    check("w1_width", width, 1);
    check("w1_latency", lat, 2);

    // WAIT_CYCLES = 15.
    b_req = 1; lat = 0; width = 0;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (b_rd) width++;
      if (b_cack && lat == 0) begin
        lat = c;
        b_req = 0;
      end
    end
    check("w15_width", width, 15);
    check("w15_latency", lat, 16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
